// File: rtl/ofs_plat_avalon_mem_rdwr_burst_fence_mapper.sv
// Avalon split-bus burst mapper. Source read and write bursts are cut into
// chunks the sink can accept: max sink burst, optional natural alignment and
// optional page limit. Write fences are enforced by draining outstanding
// chunks, and per-chunk write responses collapse to one per source burst.
// Sink requests are driven combinationally from the source or from burst
// state, so the mapper adds no request latency.
module ofs_plat_avalon_mem_rdwr_burst_fence_mapper #(
  parameter int ADDR_WIDTH           = 42,
  parameter int DATA_WIDTH           = 512,
  parameter int USER_WIDTH           = 8,
  parameter int SRC_BURST_CNT_WIDTH  = 7,
  parameter int SINK_BURST_CNT_WIDTH = 3,
  parameter int NATURAL_ALIGNMENT    = 0,
  parameter int PAGE_SIZE_LINES      = 0,
  parameter int MAX_WR_OUTSTANDING   = 256,
  parameter int USER_FENCE_BIT       = 0
) (
  input  logic                            clk,
  input  logic                            reset,

  input  logic                            src_rd_read,
  input  logic [ADDR_WIDTH-1:0]           src_rd_address,
  input  logic [SRC_BURST_CNT_WIDTH-1:0]  src_rd_burstcount,
  input  logic [USER_WIDTH-1:0]           src_rd_user,
  output logic                            src_rd_waitrequest,
  output logic [DATA_WIDTH-1:0]           src_rd_readdata,
  output logic                            src_rd_readdatavalid,
  output logic [1:0]                      src_rd_response,
  output logic [USER_WIDTH-1:0]           src_rd_readresponseuser,

  input  logic                            src_wr_write,
  input  logic [ADDR_WIDTH-1:0]           src_wr_address,
  input  logic [SRC_BURST_CNT_WIDTH-1:0]  src_wr_burstcount,
  input  logic [DATA_WIDTH-1:0]           src_wr_writedata,
  input  logic [DATA_WIDTH/8-1:0]         src_wr_byteenable,
  input  logic [USER_WIDTH-1:0]           src_wr_user,
  output logic                            src_wr_waitrequest,
  output logic                            src_wr_writeresponsevalid,
  output logic [1:0]                      src_wr_response,
  output logic [USER_WIDTH-1:0]           src_wr_writeresponseuser,

  output logic                            sink_rd_read,
  output logic [ADDR_WIDTH-1:0]           sink_rd_address,
  output logic [SINK_BURST_CNT_WIDTH-1:0] sink_rd_burstcount,
  output logic [USER_WIDTH:0]             sink_rd_user,
  input  logic                            sink_rd_waitrequest,
  input  logic [DATA_WIDTH-1:0]           sink_rd_readdata,
  input  logic                            sink_rd_readdatavalid,
  input  logic [1:0]                      sink_rd_response,
  input  logic [USER_WIDTH:0]             sink_rd_readresponseuser,

  output logic                            sink_wr_write,
  output logic [ADDR_WIDTH-1:0]           sink_wr_address,
  output logic [SINK_BURST_CNT_WIDTH-1:0] sink_wr_burstcount,
  output logic [DATA_WIDTH-1:0]           sink_wr_writedata,
  output logic [DATA_WIDTH/8-1:0]         sink_wr_byteenable,
  output logic [USER_WIDTH:0]             sink_wr_user,
  input  logic                            sink_wr_waitrequest,
  input  logic                            sink_wr_writeresponsevalid,
  input  logic [1:0]                      sink_wr_response,
  input  logic [USER_WIDTH:0]             sink_wr_writeresponseuser,

  output logic                            err_fence_burst
);

  localparam int SRC_BC  = SRC_BURST_CNT_WIDTH;
  localparam int SINK_BC = SINK_BURST_CNT_WIDTH;
  localparam int CNT_W   = $clog2(MAX_WR_OUTSTANDING + 1);

  localparam logic [ADDR_WIDTH-1:0] MAXB_A    = ADDR_WIDTH'(1) << (SINK_BC - 1);
  localparam logic [ADDR_WIDTH-1:0] PAGE_A    = ADDR_WIDTH'(PAGE_SIZE_LINES);
  localparam logic [ADDR_WIDTH-1:0] PAGE_MASK = PAGE_A - ADDR_WIDTH'(1);
  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(MAX_WR_OUTSTANDING);

  // Length of the chunk starting at a with r beats left in the source burst.
  function automatic logic [SINK_BC-1:0] chunk_len(input logic [ADDR_WIDTH-1:0] a,
                                                   input logic [SRC_BC-1:0]     r);
    logic [ADDR_WIDTH-1:0] len, left, p, best;
    len  = ADDR_WIDTH'(r);
    left = '0;
    p    = '0;
    best = ADDR_WIDTH'(1);
    if (len > MAXB_A) len = MAXB_A;
    if (PAGE_SIZE_LINES != 0) begin
      left = PAGE_A - (a & PAGE_MASK);
      if (left < len) len = left;
    end
    if (NATURAL_ALIGNMENT != 0) begin
      // Alignment to p implies alignment to every smaller power of 2, so the
      // last hit in ascending order is the largest legal size.
      for (int i = 0; i < SINK_BC; i++) begin
        p = ADDR_WIDTH'(1) << i;
        if ((p <= len) && ((a & (p - ADDR_WIDTH'(1))) == '0)) best = p;
      end
      len = best;
    end
    return SINK_BC'(len);
  endfunction

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  typedef enum logic {R_IDLE, R_SPLIT} rd_state_t;

  rd_state_t              rd_state, rd_state_nxt;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_nxt, rd_cur_addr;
  logic [SRC_BC-1:0]      rd_rem_q, rd_rem_nxt, rd_cur_rem;
  logic [USER_WIDTH-1:0]  rd_user_q, rd_user_nxt, rd_cur_user;
  logic [SINK_BC-1:0]     rd_len;
  logic                   rd_cur_req, rd_last, rd_acc;

  // Read chunk selection, source handshake and next burst state.
  always_comb begin
    rd_state_nxt = rd_state;
    rd_addr_nxt  = rd_addr_q;
    rd_rem_nxt   = rd_rem_q;
    rd_user_nxt  = rd_user_q;
    if (rd_state == R_IDLE) begin
      rd_cur_addr = src_rd_address;
      rd_cur_rem  = src_rd_burstcount;
      rd_cur_user = src_rd_user;
      rd_cur_req  = src_rd_read;
    end else begin
      rd_cur_addr = rd_addr_q;
      rd_cur_rem  = rd_rem_q;
      rd_cur_user = rd_user_q;
      rd_cur_req  = 1'b1;
    end
    rd_len  = chunk_len(rd_cur_addr, rd_cur_rem);
    rd_last = (SRC_BC'(rd_len) == rd_cur_rem);
    rd_acc  = rd_cur_req && !sink_rd_waitrequest && !reset;

    sink_rd_read       = rd_cur_req && !reset;
    sink_rd_address    = rd_cur_addr;
    sink_rd_burstcount = rd_len;
    sink_rd_user       = {rd_last, rd_cur_user};

    // The source is released only together with its final chunk.
    src_rd_waitrequest = 1'b1;
    if (!reset && rd_last) src_rd_waitrequest = sink_rd_waitrequest;

    if (rd_acc) begin
      if (rd_last) begin
        rd_state_nxt = R_IDLE;
      end else begin
        rd_state_nxt = R_SPLIT;
        rd_addr_nxt  = rd_cur_addr + ADDR_WIDTH'(rd_len);
        rd_rem_nxt   = rd_cur_rem - SRC_BC'(rd_len);
        rd_user_nxt  = rd_cur_user;
      end
    end
  end

  // Read burst state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state  <= R_IDLE;
      rd_addr_q <= '0;
      rd_rem_q  <= '0;
      rd_user_q <= '0;
    end else begin
      rd_state  <= rd_state_nxt;
      rd_addr_q <= rd_addr_nxt;
      rd_rem_q  <= rd_rem_nxt;
      rd_user_q <= rd_user_nxt;
    end
  end

  assign src_rd_readdata         = sink_rd_readdata;
  assign src_rd_readdatavalid    = sink_rd_readdatavalid && !reset;
  assign src_rd_response         = sink_rd_response;
  assign src_rd_readresponseuser = sink_rd_readresponseuser[USER_WIDTH-1:0];

  logic unused_rd_user;
  assign unused_rd_user = sink_rd_readresponseuser[USER_WIDTH];

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {W_IDLE, W_FENCE_WAIT, W_BURST} wr_state_t;

  wr_state_t              wr_state, wr_state_nxt;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_nxt, wr_cur_addr;   // next chunk address
  logic [SRC_BC-1:0]      wr_left_q, wr_left_nxt, wr_cur_rem;    // source beats after current chunk
  logic [SINK_BC-1:0]     wr_beats_q, wr_beats_nxt;              // beats still owed in current chunk
  logic [USER_WIDTH-1:0]  wr_user_q, wr_user_nxt, wr_cur_user;
  logic [SINK_BC-1:0]     wr_len;
  logic [CNT_W-1:0]       wr_cnt_q;
  logic                   wr_in_burst, wr_first, wr_last, wr_fence, wr_fence_block;
  logic                   wr_hold, wr_acc, wr_issue;

  // Write chunk selection, fence/credit holds and next burst state.
  always_comb begin
    wr_state_nxt = wr_state;
    wr_addr_nxt  = wr_addr_q;
    wr_left_nxt  = wr_left_q;
    wr_beats_nxt = wr_beats_q;
    wr_user_nxt  = wr_user_q;

    wr_in_burst = (wr_state == W_BURST);
    wr_first    = !wr_in_burst || (wr_beats_q == '0);
    wr_cur_addr = wr_in_burst ? wr_addr_q : src_wr_address;
    wr_cur_rem  = wr_in_burst ? wr_left_q : src_wr_burstcount;
    wr_cur_user = wr_in_burst ? wr_user_q : src_wr_user;
    wr_len      = chunk_len(wr_cur_addr, wr_cur_rem);
    wr_last     = wr_first ? (SRC_BC'(wr_len) == wr_cur_rem) : (wr_left_q == '0);

    // Fences are only recognised on the first beat of a source burst.
    wr_fence       = !wr_in_burst && src_wr_user[USER_FENCE_BIT];
    wr_fence_block = src_wr_write && wr_fence && (wr_cnt_q != '0);
    wr_hold        = wr_first && ((wr_cnt_q == CNT_MAX) || wr_fence_block);

    sink_wr_write      = src_wr_write && !wr_hold && !reset;
    sink_wr_address    = wr_cur_addr;
    sink_wr_burstcount = wr_len;
    sink_wr_writedata  = src_wr_writedata;
    sink_wr_byteenable = src_wr_byteenable;
    sink_wr_user       = {wr_last, wr_cur_user};
    src_wr_waitrequest = reset || wr_hold || sink_wr_waitrequest;

    wr_acc   = sink_wr_write && !sink_wr_waitrequest;
    wr_issue = wr_acc && wr_first;

    if (!wr_in_burst) begin
      wr_state_nxt = wr_fence_block ? W_FENCE_WAIT : W_IDLE;
      if (wr_acc && (wr_cur_rem != SRC_BC'(1))) begin
        wr_state_nxt = W_BURST;
        wr_beats_nxt = wr_len - SINK_BC'(1);
        wr_left_nxt  = wr_cur_rem - SRC_BC'(wr_len);
        wr_addr_nxt  = wr_cur_addr + ADDR_WIDTH'(wr_len);
        wr_user_nxt  = wr_cur_user;
      end
    end else if (wr_acc) begin
      if (wr_first) begin
        wr_beats_nxt = wr_len - SINK_BC'(1);
        wr_left_nxt  = wr_left_q - SRC_BC'(wr_len);
        wr_addr_nxt  = wr_addr_q + ADDR_WIDTH'(wr_len);
        if (wr_left_q == SRC_BC'(1)) wr_state_nxt = W_IDLE;
      end else begin
        wr_beats_nxt = wr_beats_q - SINK_BC'(1);
        if ((wr_beats_q == SINK_BC'(1)) && (wr_left_q == '0)) wr_state_nxt = W_IDLE;
      end
    end
  end

  // Write burst state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state   <= W_IDLE;
      wr_addr_q  <= '0;
      wr_left_q  <= '0;
      wr_beats_q <= '0;
      wr_user_q  <= '0;
    end else begin
      wr_state   <= wr_state_nxt;
      wr_addr_q  <= wr_addr_nxt;
      wr_left_q  <= wr_left_nxt;
      wr_beats_q <= wr_beats_nxt;
      wr_user_q  <= wr_user_nxt;
    end
  end

  // Outstanding sink write chunks; simultaneous issue and response cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_q <= '0;
    end else begin
      case ({wr_issue, sink_wr_writeresponsevalid})
        2'b10:   wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        2'b01:   wr_cnt_q <= wr_cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Sticky flag for fences that are not single-beat bursts.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_fence_burst <= 1'b0;
    end else if (wr_issue && wr_fence && (src_wr_burstcount != SRC_BC'(1))) begin
      err_fence_burst <= 1'b1;
    end
  end

  // Only the response tagged as the last chunk of a source burst goes upstream.
  assign src_wr_writeresponsevalid = sink_wr_writeresponsevalid &&
                                     sink_wr_writeresponseuser[USER_WIDTH] && !reset;
  assign src_wr_response           = sink_wr_response;
  assign src_wr_writeresponseuser  = sink_wr_writeresponseuser[USER_WIDTH-1:0];

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_burst_fence_mapper.sv
// Directed bench: instance 0 (MAX_WR_OUTSTANDING=8) and instance 1
// (MAX_WR_OUTSTANDING=2) share inputs; both use MAXB=4, natural alignment
// and 64-line pages.
module tb_ofs_plat_avalon_mem_rdwr_burst_fence_mapper;
  localparam int AW = 42, DW = 64, UW = 8, SBW = 7, KBW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            src_rd_read;
  logic [AW-1:0]   src_rd_address;
  logic [SBW-1:0]  src_rd_burstcount;
  logic [UW-1:0]   src_rd_user;
  logic            src_wr_write;
  logic [AW-1:0]   src_wr_address;
  logic [SBW-1:0]  src_wr_burstcount;
  logic [DW-1:0]   src_wr_writedata;
  logic [DW/8-1:0] src_wr_byteenable;
  logic [UW-1:0]   src_wr_user;
  logic            sink_rd_waitrequest;
  logic [DW-1:0]   sink_rd_readdata;
  logic            sink_rd_readdatavalid;
  logic [1:0]      sink_rd_response;
  logic [UW:0]     sink_rd_readresponseuser;
  logic            sink_wr_waitrequest;
  logic            sink_wr_writeresponsevalid;
  logic [1:0]      sink_wr_response;
  logic [UW:0]     sink_wr_writeresponseuser;

  logic            src_rd_waitrequest [2];
  logic [DW-1:0]   src_rd_readdata [2];
  logic            src_rd_readdatavalid [2];
  logic [1:0]      src_rd_response [2];
  logic [UW-1:0]   src_rd_readresponseuser [2];
  logic            src_wr_waitrequest [2];
  logic            src_wr_writeresponsevalid [2];
  logic [1:0]      src_wr_response [2];
  logic [UW-1:0]   src_wr_writeresponseuser [2];
  logic            sink_rd_read [2];
  logic [AW-1:0]   sink_rd_address [2];
  logic [KBW-1:0]  sink_rd_burstcount [2];
  logic [UW:0]     sink_rd_user [2];
  logic            sink_wr_write [2];
  logic [AW-1:0]   sink_wr_address [2];
  logic [KBW-1:0]  sink_wr_burstcount [2];
  logic [DW-1:0]   sink_wr_writedata [2];
  logic [DW/8-1:0] sink_wr_byteenable [2];
  logic [UW:0]     sink_wr_user [2];
  logic            err_fence_burst [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ofs_plat_avalon_mem_rdwr_burst_fence_mapper #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW),
      .SRC_BURST_CNT_WIDTH(SBW), .SINK_BURST_CNT_WIDTH(KBW),
      .NATURAL_ALIGNMENT(1), .PAGE_SIZE_LINES(64),
      .MAX_WR_OUTSTANDING((g == 0) ? 8 : 2), .USER_FENCE_BIT(0)
    ) u_dut (
      .clk(clk), .reset(reset),
      .src_rd_read(src_rd_read), .src_rd_address(src_rd_address),
      .src_rd_burstcount(src_rd_burstcount), .src_rd_user(src_rd_user),
      .src_rd_waitrequest(src_rd_waitrequest[g]), .src_rd_readdata(src_rd_readdata[g]),
      .src_rd_readdatavalid(src_rd_readdatavalid[g]), .src_rd_response(src_rd_response[g]),
      .src_rd_readresponseuser(src_rd_readresponseuser[g]),
      .src_wr_write(src_wr_write), .src_wr_address(src_wr_address),
      .src_wr_burstcount(src_wr_burstcount), .src_wr_writedata(src_wr_writedata),
      .src_wr_byteenable(src_wr_byteenable), .src_wr_user(src_wr_user),
      .src_wr_waitrequest(src_wr_waitrequest[g]),
      .src_wr_writeresponsevalid(src_wr_writeresponsevalid[g]),
      .src_wr_response(src_wr_response[g]), .src_wr_writeresponseuser(src_wr_writeresponseuser[g]),
      .sink_rd_read(sink_rd_read[g]), .sink_rd_address(sink_rd_address[g]),
      .sink_rd_burstcount(sink_rd_burstcount[g]), .sink_rd_user(sink_rd_user[g]),
      .sink_rd_waitrequest(sink_rd_waitrequest), .sink_rd_readdata(sink_rd_readdata),
      .sink_rd_readdatavalid(sink_rd_readdatavalid), .sink_rd_response(sink_rd_response),
      .sink_rd_readresponseuser(sink_rd_readresponseuser),
      .sink_wr_write(sink_wr_write[g]), .sink_wr_address(sink_wr_address[g]),
      .sink_wr_burstcount(sink_wr_burstcount[g]), .sink_wr_writedata(sink_wr_writedata[g]),
      .sink_wr_byteenable(sink_wr_byteenable[g]), .sink_wr_user(sink_wr_user[g]),
      .sink_wr_waitrequest(sink_wr_waitrequest),
      .sink_wr_writeresponsevalid(sink_wr_writeresponsevalid),
      .sink_wr_response(sink_wr_response), .sink_wr_writeresponseuser(sink_wr_writeresponseuser),
      .err_fence_burst(err_fence_burst[g])
    );
  end

  typedef struct {
    logic [AW-1:0]  addr;
    logic [SBW-1:0] bc;
    logic [KBW-1:0] len;   // expected first-chunk length
    logic           last;  // expected last-chunk user bit
  } vec_t;

  vec_t vecs [10];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    src_rd_read = 0; src_rd_address = '0; src_rd_burstcount = 7'd1; src_rd_user = '0;
    src_wr_write = 0; src_wr_address = '0; src_wr_burstcount = 7'd1;
    src_wr_writedata = '0; src_wr_byteenable = '1; src_wr_user = '0;
    sink_rd_waitrequest = 0; sink_rd_readdata = '0; sink_rd_readdatavalid = 0;
    sink_rd_response = '0; sink_rd_readresponseuser = '0;
    sink_wr_waitrequest = 0; sink_wr_writeresponsevalid = 0;
    sink_wr_response = '0; sink_wr_writeresponseuser = '0;
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs();
    tick(); tick();
    reset = 0;
    tick();
  endtask

  task automatic wr_single(input logic [AW-1:0] a);
    src_wr_write = 1; src_wr_address = a; src_wr_burstcount = 7'd1; src_wr_user = '0;
  endtask

  initial begin
    int ra [4];
    int rl [4];
    vecs[0] = '{42'h00, 7'd1,  3'd1, 1'b1};
    vecs[1] = '{42'h00, 7'd8,  3'd4, 1'b0};
    vecs[2] = '{42'h03, 7'd8,  3'd1, 1'b0};
    vecs[3] = '{42'h06, 7'd4,  3'd2, 1'b0};
    vecs[4] = '{42'h3E, 7'd4,  3'd2, 1'b0};
    vecs[5] = '{42'h3F, 7'd2,  3'd1, 1'b0};
    vecs[6] = '{42'h08, 7'd3,  3'd2, 1'b0};
    vecs[7] = '{42'h10, 7'd4,  3'd4, 1'b1};
    vecs[8] = '{42'h40, 7'd64, 3'd4, 1'b0};
    vecs[9] = '{42'h7C, 7'd2,  3'd2, 1'b1};
    ra = '{3, 4, 8, 10};
    rl = '{1, 4, 2, 1};

    // Reset state with requests pending on the source side.
    idle_inputs(); reset = 1;
    src_rd_read = 1; src_wr_write = 1;
    sink_rd_readdatavalid = 1; sink_wr_writeresponsevalid = 1; sink_wr_writeresponseuser = 9'h100;
    tick(); tick(); #2;
    chk("rst_src_rd_wait", 64'(src_rd_waitrequest[0]), 64'd1);
    chk("rst_src_wr_wait", 64'(src_wr_waitrequest[0]), 64'd1);
    chk("rst_sink_rd_read", 64'(sink_rd_read[0]), 64'd0);
    chk("rst_sink_wr_write", 64'(sink_wr_write[0]), 64'd0);
    chk("rst_err", 64'(err_fence_burst[0]), 64'd0);
    chk("rst_rd_valid_gate", 64'(src_rd_readdatavalid[0]), 64'd0);
    chk("rst_wr_resp_gate", 64'(src_wr_writeresponsevalid[0]), 64'd0);
    do_reset();

    // First-chunk lengths; sink stalled so no state moves.
    sink_rd_waitrequest = 1; sink_wr_waitrequest = 1;
    for (int i = 0; i < 10; i++) begin
      src_rd_read = 1; src_rd_address = vecs[i].addr; src_rd_burstcount = vecs[i].bc;
      src_wr_write = 1; src_wr_address = vecs[i].addr; src_wr_burstcount = vecs[i].bc;
      #2;
      chk($sformatf("vec%0d_rd_len", i), 64'(sink_rd_burstcount[0]), 64'(vecs[i].len));
      chk($sformatf("vec%0d_rd_last", i), 64'(sink_rd_user[0][UW]), 64'(vecs[i].last));
      chk($sformatf("vec%0d_wr_len", i), 64'(sink_wr_burstcount[0]), 64'(vecs[i].len));
      chk($sformatf("vec%0d_wr_last", i), 64'(sink_wr_user[0][UW]), 64'(vecs[i].last));
      tick();
    end

    // Read alignment split: 0x3/8 -> (3,1) (4,4) (8,2) (A,1).
    do_reset();
    src_rd_read = 1; src_rd_address = 42'h3; src_rd_burstcount = 7'd8; src_rd_user = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("rsplit%0d_addr", i), 64'(sink_rd_address[0]), 64'(ra[i]));
      chk($sformatf("rsplit%0d_len", i), 64'(sink_rd_burstcount[0]), 64'(rl[i]));
      chk($sformatf("rsplit%0d_user", i), 64'(sink_rd_user[0][UW-1:0]), 64'h5A);
      chk($sformatf("rsplit%0d_wait", i), 64'(src_rd_waitrequest[0]), (i == 3) ? 64'd0 : 64'd1);
      tick();
    end
    src_rd_read = 0; #2;
    chk("rsplit_done_read", 64'(sink_rd_read[0]), 64'd0);

    // Write page split: 0x3E/4 -> (3E,2,last=0) (40,2,last=1), one response.
    do_reset();
    src_wr_write = 1; src_wr_address = 42'h3E; src_wr_burstcount = 7'd4;
    for (int i = 0; i < 4; i++) begin
      src_wr_writedata = 64'hA0 + 64'(i);
      #2;
      chk($sformatf("wsplit%0d_write", i), 64'(sink_wr_write[0]), 64'd1);
      chk($sformatf("wsplit%0d_data", i), sink_wr_writedata[0], 64'hA0 + 64'(i));
      chk($sformatf("wsplit%0d_wait", i), 64'(src_wr_waitrequest[0]), 64'd0);
      if (i == 0 || i == 2) begin
        chk($sformatf("wsplit%0d_addr", i), 64'(sink_wr_address[0]), (i == 0) ? 64'h3E : 64'h40);
        chk($sformatf("wsplit%0d_len", i), 64'(sink_wr_burstcount[0]), 64'd2);
        chk($sformatf("wsplit%0d_last", i), 64'(sink_wr_user[0][UW]), (i == 0) ? 64'd0 : 64'd1);
      end
      tick();
    end
    src_wr_write = 0;
    sink_wr_writeresponsevalid = 1; sink_wr_writeresponseuser = 9'h000; #2;
    chk("wsplit_resp1_silent", 64'(src_wr_writeresponsevalid[0]), 64'd0);
    tick();
    sink_wr_writeresponseuser = 9'h133; #2;
    chk("wsplit_resp2_valid", 64'(src_wr_writeresponsevalid[0]), 64'd1);
    chk("wsplit_resp2_user", 64'(src_wr_writeresponseuser[0]), 64'h33);
    tick();
    sink_wr_writeresponsevalid = 0;

    // Fence wait: 3 chunks outstanding, fence released after the 3rd response.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_single(AW'(i)); #2;
      chk($sformatf("fence_pre%0d_wait", i), 64'(src_wr_waitrequest[0]), 64'd0);
      tick();
    end
    wr_single(42'h10); src_wr_user = 8'h01;
    for (int i = 0; i < 4; i++) begin
      sink_wr_writeresponsevalid = (i != 0); sink_wr_writeresponseuser = 9'h100;
      #2;
      chk($sformatf("fence_hold%0d_write", i), 64'(sink_wr_write[0]), 64'd0);
      chk($sformatf("fence_hold%0d_wait", i), 64'(src_wr_waitrequest[0]), 64'd1);
      tick();
    end
    sink_wr_writeresponsevalid = 0; #2;
    chk("fence_rel_write", 64'(sink_wr_write[0]), 64'd1);
    chk("fence_rel_addr", 64'(sink_wr_address[0]), 64'h10);
    chk("fence_rel_wait", 64'(src_wr_waitrequest[0]), 64'd0);
    chk("fence_rel_err", 64'(err_fence_burst[0]), 64'd0);
    tick();
    src_wr_write = 0;

    // Fence burst error: burstcount 2 still forwarded, flag sticks.
    do_reset();
    src_wr_write = 1; src_wr_address = 42'h20; src_wr_burstcount = 7'd2; src_wr_user = 8'h01;
    #2;
    chk("ferr_beat0_write", 64'(sink_wr_write[0]), 64'd1);
    chk("ferr_beat0_len", 64'(sink_wr_burstcount[0]), 64'd2);
    chk("ferr_before", 64'(err_fence_burst[0]), 64'd0);
    tick(); #2;
    chk("ferr_beat1_write", 64'(sink_wr_write[0]), 64'd1);
    chk("ferr_set", 64'(err_fence_burst[0]), 64'd1);
    tick();
    src_wr_write = 0;
    tick(); tick(); #2;
    chk("ferr_sticky", 64'(err_fence_burst[0]), 64'd1);

    // Credit limit on instance 1 (max 2), including a same-cycle issue+response.
    do_reset();
    wr_single(42'h0); #2;
    chk("cred_a_wait", 64'(src_wr_waitrequest[1]), 64'd0);
    tick();
    wr_single(42'h1); sink_wr_writeresponsevalid = 1; sink_wr_writeresponseuser = 9'h100; #2;
    chk("cred_b_wait", 64'(src_wr_waitrequest[1]), 64'd0);
    chk("cred_b_resp", 64'(src_wr_writeresponsevalid[1]), 64'd1);
    tick();
    wr_single(42'h2); sink_wr_writeresponsevalid = 0; #2;
    chk("cred_c_write", 64'(sink_wr_write[1]), 64'd1);
    tick();
    wr_single(42'h3); #2;
    chk("cred_d_held_write", 64'(sink_wr_write[1]), 64'd0);
    chk("cred_d_held_wait", 64'(src_wr_waitrequest[1]), 64'd1);
    tick();
    sink_wr_writeresponsevalid = 1; #2;
    chk("cred_d_held2_write", 64'(sink_wr_write[1]), 64'd0);
    tick();
    sink_wr_writeresponsevalid = 0; #2;
    chk("cred_d_rel_write", 64'(sink_wr_write[1]), 64'd1);
    chk("cred_d_rel_addr", 64'(sink_wr_address[1]), 64'h3);
    chk("cred_d_rel_wait", 64'(src_wr_waitrequest[1]), 64'd0);
    tick();
    src_wr_write = 0;

    // Reset in the middle of a read split and a write burst.
    do_reset();
    src_rd_read = 1; src_rd_address = 42'h0; src_rd_burstcount = 7'd16;
    src_wr_write = 1; src_wr_address = 42'h0; src_wr_burstcount = 7'd8;
    tick(); tick();
    reset = 1; #2;
    chk("midrst_rd_read", 64'(sink_rd_read[0]), 64'd0);
    chk("midrst_wr_write", 64'(sink_wr_write[0]), 64'd0);
    chk("midrst_rd_wait", 64'(src_rd_waitrequest[0]), 64'd1);
    chk("midrst_wr_wait", 64'(src_wr_waitrequest[0]), 64'd1);
    tick();
    reset = 0;
    src_rd_address = 42'h20; src_rd_burstcount = 7'd1;
    src_wr_address = 42'h30; src_wr_burstcount = 7'd1; src_wr_user = 8'h01;
    sink_rd_readdatavalid = 1; sink_rd_readdata = 64'hDEAD_BEEF; sink_rd_readresponseuser = 9'h1AB;
    #2;
    chk("post_rd_addr", 64'(sink_rd_address[0]), 64'h20);
    chk("post_rd_wait", 64'(src_rd_waitrequest[0]), 64'd0);
    chk("post_wr_write", 64'(sink_wr_write[0]), 64'd1);
    chk("post_wr_addr", 64'(sink_wr_address[0]), 64'h30);
    chk("post_wr_wait", 64'(src_wr_waitrequest[0]), 64'd0);
    chk("post_rd_valid", 64'(src_rd_readdatavalid[0]), 64'd1);
    chk("post_rd_data", src_rd_readdata[0], 64'hDEAD_BEEF);
    chk("post_rd_user", 64'(src_rd_readresponseuser[0]), 64'hAB);
    tick();
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
